axis_video_pattern_gen: RTL
===========================

// Module: axis_video_pattern_gen
// PURPOSE
//  Synthesizable, parametrised AXI4-Stream video source for the camera -> YCbCr -> SlantMem -> HDMI chain.
//  Emits whole frames (tuser on first pixel, tlast on each line end) with programmable geometry, blanking gaps and pattern.
//  Honours m_axis_video_tready backpressure. Supports bring-up on hardware without the camera.
// PARAMETERS
//  H_ACTIVE   640     pixels per line (>=2)
//  V_ACTIVE   480     lines per frame (>=1)
//  CH         3       colour channels in tdata
//  COMP_W     6       significant bits per channel, MSB-aligned in 8, LSBs zero
//  LINE_GAP   1750    idle cycles after each tlast transfer (0 allowed)
//  FRAME_GAP  500000  idle cycles after the last line of a frame (0 allowed)
//  ON_CYC     4       throttle: offered pixels per burst (PATGEN_THROTTLE_EN only)
//  OFF_CYC    3       throttle: idle cycles between bursts (PATGEN_THROTTLE_EN only)
// PORTS
//  clk                  in   1        clock
//  rstn                 in   1        reset, asynchronous, active-low
//  start                in   1        pulse: begin run; ignored unless IDLE
//  enable               in   1        0 = stop after current frame completes
//  cfg_mode             in   2        0 counter, 1 colour bars, 2 H-ramp, 3 solid
//  cfg_frames           in   16       frames per run; 0 = continuous
//  cfg_color            in   8*CH     solid colour (mode 3)
//  m_axis_video_tdata   out  8*CH     pixel, ch0 in LSBs
//  m_axis_video_tvalid  out  1
//  m_axis_video_tready  in   1
//  m_axis_video_tuser   out  1        start of frame
//  m_axis_video_tlast   out  1        end of line
//  busy                 out  1        high in any state except IDLE
//  frame_done           out  1        1-cycle pulse on the last-pixel transfer of a frame
//  frame_cnt            out  16       frames completed this run; wraps at 2^16
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; x, y, gap and pixel counters 0.
//  FSM states: IDLE, ACTIVE, LGAP, FGAP.
//   - IDLE -> ACTIVE on start && enable; cfg_mode, cfg_frames and cfg_color latched; frame_cnt cleared.
//   - ACTIVE -> LGAP on a tlast transfer, unless the line is the last line.
//   - ACTIVE -> FGAP on the tlast transfer of the last line.
//   - LGAP -> ACTIVE after LINE_GAP cycles.
//   - FGAP -> ACTIVE after FRAME_GAP cycles if enable && frames remain.
//   - FGAP -> IDLE otherwise.
//   - A gap of 0 means the next pixel is offered on the cycle after the transfer.
//  Transfer = tvalid && tready.
//   - Once tvalid is high, tdata, tuser and tlast are held stable until the transfer.
//   - tvalid never drops without a transfer.
//  tuser = (x==0 && y==0); tlast = (x==H_ACTIVE-1). x and y advance only on transfer.
//  Latency: first tvalid is on the cycle after start is sampled (registered outputs).
//  Patterns (v = COMP_W-bit field; channel byte = {v, (8-COMP_W)'b0}):
//   - mode 0: pcnt (CH*COMP_W bits) increments per transfer and wraps; ch k = pcnt[k*COMP_W +: COMP_W].
//     pcnt clears at start only, not per frame.
//   - mode 1: 8 equal vertical bars, bar b = x*8/H_ACTIVE.
//     ch k = all ones if bit k of b is set, else 0 (bit 2 selects ch2).
//   - mode 2: every ch = x[COMP_W-1:0].
//   - mode 3: channel bytes = latched cfg_color.
//  enable deasserted mid-frame: the frame completes normally, then FGAP -> IDLE (no truncated frames).
//  frame_done/frame_cnt update on the final transfer. Run ends when frame_cnt == cfg_frames (cfg_frames != 0).
//  tready low throughout: the generator stalls indefinitely with no data loss; gap counters start only after the transfer.
//  rstn asserted mid-line: immediate return to reset values; no partial-frame resume.
// CONFIGURATION
//  PATGEN_THROTTLE_EN defined:
//   - In ACTIVE, tvalid follows ON_CYC offered pixels then OFF_CYC idle cycles.
//   - The burst counter advances on transfers; the OFF phase starts only after the ON_CYC-th transfer.
//   - The burst counter resets at each line start.
//  PATGEN_THROTTLE_EN undefined: tvalid is continuously high in ACTIVE; ON_CYC and OFF_CYC are unused.
// STRUCTURE
//  Package video_pkg:
//   - pattern-mode localparams (PAT_CNT, PAT_BARS, PAT_RAMP, PAT_SOLID)
//   - FSM state encoding
//   - function comp_pack(v) for MSB-aligned padding
//  One sub-module, axis_pattern_pixel: combinational pixel formatter.
//   - Inputs: mode, x, pcnt, color. Output: tdata.
//   - The top module registers its output.
// TESTING  (bench params H_ACTIVE=16, V_ACTIVE=4, LINE_GAP=10, FRAME_GAP=20, COMP_W=6, CH=3)
//  1. mode0, frames=1, tready=1:
//     - 64 transfers: tdata 0x000000, 0x000004, 0x000008...
//     - tuser on transfer 0 only; tlast on transfers 15, 31, 47, 63.
//     - frame_done once; frame_cnt=1; busy falls after 20 idle cycles.
//  2. Random tready (50%):
//     - tdata, tuser and tlast stable while tvalid && !tready.
//     - Same 64-pixel sequence as scenario 1.
//  3. mode1, one line: x=0..1 -> 0x000000; x=2..3 -> 0x0000FC; x=14..15 -> 0xFCFCFC.
//  4. frames=0, drop enable at pixel 20 of frame 2 -> frame 2 completes, frame_cnt=2, IDLE after FRAME_GAP.
//  5. rstn low at pixel 5, then start again -> first pixel tuser=1, tdata=0x000000.
//  6. PATGEN_THROTTLE_EN, tready=1 -> tvalid pattern 1111000 repeating; tlast at transfer 16 followed by 10-cycle gap.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: pattern-mode codes, FSM state encoding and component packing helper
// No ports; imported by axis_pattern_pixel and axis_video_pattern_gen.
package video_pkg;
  localparam logic [1:0] PAT_CNT = 2'd0;
  localparam logic [1:0] PAT_BARS = 2'd1;
  localparam logic [1:0] PAT_RAMP = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LGAP, S_FGAP} state_t;
  function automatic logic [7:0] comp_pack(input logic [7:0] v, input int w);
    return v << (8 - w);
  endfunction
endpackage

// File: rtl/axis_pattern_pixel.sv
// axis_pattern_pixel: combinational pixel formatter for the pattern generator
// Ports: mode_i (pattern select), x_i (pixel column), pcnt_i (running pixel count),
//        color_i (solid colour bytes), tdata_o (packed pixel, ch0 in LSBs).
module axis_pattern_pixel
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int CH = 3,
  parameter int COMP_W = 6,
  parameter int XW = 10
) (
  input  logic [1:0]         mode_i,
  input  logic [XW-1:0]      x_i,
  input  logic [CH*COMP_W-1:0] pcnt_i,
  input  logic [8*CH-1:0]    color_i,
  output logic [8*CH-1:0]    tdata_o
);
  logic [2:0] bar;
  logic [7:0] ones;
  logic [7:0] ramp;
  always_comb begin
    tdata_o = '0;
    bar = 3'((32'(x_i) * 8) / H_ACTIVE);
    ones = comp_pack(8'((1 << COMP_W) - 1), COMP_W);
    ramp = comp_pack(8'(32'(x_i) % (1 << COMP_W)), COMP_W);
    for (int k = 0; k < CH; k++)
      tdata_o[8*k +: 8] = mode_i == PAT_CNT  ? comp_pack(8'(pcnt_i[k*COMP_W +: COMP_W]), COMP_W) :
                          mode_i == PAT_BARS ? (((32'(bar) >> k) & 32'd1) != 0 ? ones : 8'd0) :
                          mode_i == PAT_RAMP ? ramp : color_i[8*k +: 8];
  end
endmodule

// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen: AXI4-Stream video test-pattern source with blanking gaps and backpressure
// Ports: clk, rstn (async active-low); start/enable run control; cfg_mode/cfg_frames/cfg_color
//        latched at run start; m_axis_video_* stream master; busy, frame_done, frame_cnt status.
// Optional build macro PATGEN_THROTTLE_EN: ON_CYC-pixel bursts separated by OFF_CYC idle cycles.
module axis_video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CH = 3,
  parameter int COMP_W = 6,
  parameter int LINE_GAP = 1750,
  parameter int FRAME_GAP = 500000,
  parameter int ON_CYC = 4,
  parameter int OFF_CYC = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            enable,
  input  logic [1:0]      cfg_mode,
  input  logic [15:0]     cfg_frames,
  input  logic [8*CH-1:0] cfg_color,
  output logic [8*CH-1:0] m_axis_video_tdata,
  output logic            m_axis_video_tvalid,
  input  logic            m_axis_video_tready,
  output logic            m_axis_video_tuser,
  output logic            m_axis_video_tlast,
  output logic            busy,
  output logic            frame_done,
  output logic [15:0]     frame_cnt
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  localparam int PW = CH * COMP_W;
  localparam int GM = LINE_GAP > FRAME_GAP ? (LINE_GAP > OFF_CYC ? LINE_GAP : OFF_CYC)
                                           : (FRAME_GAP > OFF_CYC ? FRAME_GAP : OFF_CYC);
  localparam int GW = $clog2(GM + 2);
  localparam int BW = $clog2(ON_CYC + 1);
`ifdef PATGEN_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] bc_q, bc_d;
  logic off_q, off_d;
  logic [1:0] mode_q, mode_d;
  logic [15:0] frames_q, frames_d, fcnt_q, fcnt_d, fcnt_inc;
  logic [8*CH-1:0] color_q, color_d, tdata_q, pix;
  logic tvalid_q, tuser_q, tlast_q, fdone_q, fdone_d;
  logic xfer, last_x, last_y, more_now, more_gap, run_d;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    gap_d = gap_q;
    pcnt_d = pcnt_q;
    bc_d = bc_q;
    off_d = off_q;
    mode_d = mode_q;
    frames_d = frames_q;
    color_d = color_q;
    fcnt_d = fcnt_q;
    fdone_d = 1'b0;
    xfer = tvalid_q && m_axis_video_tready;
    last_x = x_q == XW'(H_ACTIVE - 1);
    last_y = y_q == YW'(V_ACTIVE - 1);
    fcnt_inc = fcnt_q + 16'd1;
    more_now = enable && (frames_q == '0 || fcnt_inc != frames_q);
    more_gap = enable && (frames_q == '0 || fcnt_q != frames_q);
    case (state_q)
      S_IDLE: if (start && enable) begin
        state_d = S_ACTIVE;
        mode_d = cfg_mode;
        frames_d = cfg_frames;
        color_d = cfg_color;
        fcnt_d = '0;
        x_d = '0;
        y_d = '0;
        pcnt_d = '0;
        gap_d = '0;
        bc_d = '0;
        off_d = 1'b0;
      end
      S_ACTIVE: if (off_q) begin
        gap_d = gap_q == GW'(OFF_CYC - 1) ? '0 : gap_q + 1'b1;
        off_d = gap_q != GW'(OFF_CYC - 1);
      end else if (xfer) begin
        pcnt_d = pcnt_q + 1'b1;
        bc_d = bc_q == BW'(ON_CYC - 1) ? '0 : bc_q + 1'b1;
        off_d = THR && OFF_CYC != 0 && bc_q == BW'(ON_CYC - 1);
        x_d = last_x ? '0 : x_q + 1'b1;
        if (last_x) begin
          // every line restarts the burst pattern; the line/frame gap replaces any OFF phase
          bc_d = '0;
          off_d = 1'b0;
          if (last_y) begin
            y_d = '0;
            fcnt_d = fcnt_inc;
            fdone_d = 1'b1;
            state_d = FRAME_GAP != 0 ? S_FGAP : more_now ? S_ACTIVE : S_IDLE;
          end else begin
            y_d = y_q + 1'b1;
            state_d = LINE_GAP != 0 ? S_LGAP : S_ACTIVE;
          end
        end
      end
      S_LGAP: begin
        gap_d = gap_q == GW'(LINE_GAP - 1) ? '0 : gap_q + 1'b1;
        state_d = gap_q == GW'(LINE_GAP - 1) ? S_ACTIVE : S_LGAP;
      end
      S_FGAP: begin
        gap_d = gap_q == GW'(FRAME_GAP - 1) ? '0 : gap_q + 1'b1;
        state_d = gap_q != GW'(FRAME_GAP - 1) ? S_FGAP : more_gap ? S_ACTIVE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    run_d = state_d != S_IDLE;
  end
  // outputs are registered from next-state values so they describe the pixel being offered
  axis_pattern_pixel #(.H_ACTIVE(H_ACTIVE), .CH(CH), .COMP_W(COMP_W), .XW(XW)) u_pix (
    .mode_i(mode_d), .x_i(x_d), .pcnt_i(pcnt_d), .color_i(color_d), .tdata_o(pix)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      x_q <= '0;
      y_q <= '0;
      gap_q <= '0;
      pcnt_q <= '0;
      bc_q <= '0;
      off_q <= 1'b0;
      mode_q <= '0;
      frames_q <= '0;
      color_q <= '0;
      fcnt_q <= '0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tuser_q <= 1'b0;
      tlast_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      gap_q <= gap_d;
      pcnt_q <= pcnt_d;
      bc_q <= bc_d;
      off_q <= off_d;
      mode_q <= mode_d;
      frames_q <= frames_d;
      color_q <= color_d;
      fcnt_q <= fcnt_d;
      tdata_q <= run_d ? pix : '0;
      tvalid_q <= state_d == S_ACTIVE && !off_d;
      tuser_q <= run_d && x_d == '0 && y_d == '0;
      tlast_q <= run_d && x_d == XW'(H_ACTIVE - 1);
      fdone_q <= fdone_d;
    end
  assign m_axis_video_tdata = tdata_q;
  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tuser = tuser_q;
  assign m_axis_video_tlast = tlast_q;
  assign busy = state_q != S_IDLE;
  assign frame_done = fdone_q;
  assign frame_cnt = fcnt_q;
endmodule
